// File: rtl/divide_fix_pkg.sv
// Shared types and derived sizes for the sequential fixed-point divider.
package divide_fix_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  // Word width of the Q(h).(f) format.
  function automatic int word_w(input int h, input int f);
    return h + f;
  endfunction

  // One quotient bit per cycle over the numerator |data_i|*2^f.
  function automatic int iter_n(input int h, input int f);
    return h + 2 * f;
  endfunction

  function automatic int cnt_w(input int h, input int f);
    int n;
    n = iter_n(h, f);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Saturation limits for a w-bit two's-complement word, as raw bit patterns.
  function automatic logic [63:0] max_pos(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] min_neg(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/divide_fix_step.sv
// Combinational single restoring-division step.
module divide_fix_step #(
  parameter int W = 25
) (
  input  logic [W:0] rem_i,
  input  logic       num_bit_i,
  input  logic [W:0] dvs_i,
  output logic [W:0] rem_o,
  output logic       q_bit_o
);

  logic [W+1:0] sh;

  // Shift in the next numerator bit, subtract the divisor when it fits.
  always_comb begin
    sh      = {rem_i, num_bit_i};
    q_bit_o = (sh >= {1'b0, dvs_i});
    rem_o   = q_bit_o ? (sh[W:0] - dvs_i) : sh[W:0];
  end

endmodule

// File: rtl/divide_fix_seq.sv
// Multi-cycle signed Q(width_H).(width_W) divider, one quotient bit per clock.
module divide_fix_seq #(
  parameter int width_H = 5,
  parameter int width_W = 20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       data_i_en,
  input  logic [width_H+width_W-1:0] data_i,
  input  logic [width_H+width_W-1:0] div_i,
  output logic                       busy,
  output logic                       data_o_en,
  output logic [width_H+width_W-1:0] data_o,
  output logic                       sat_o,
  output logic                       div_zero_o
);
  import divide_fix_pkg::*;

  localparam int W  = word_w(width_H, width_W);
  localparam int N  = iter_n(width_H, width_W);
  localparam int CW = cnt_w(width_H, width_W);

  localparam logic [W-1:0]  MAX_POS   = W'(max_pos(W));
  localparam logic [W-1:0]  MIN_NEG   = W'(min_neg(W));
  localparam logic [N-1:0]  MAX_POS_N = N'(max_pos(W));
  localparam logic [N-1:0]  MIN_NEG_N = N'(min_neg(W));
  localparam logic [CW-1:0] CNT_LAST  = CW'(N - 1);

  state_t        state_q, state_d;
  logic          load, step, last;
  logic [CW-1:0] cnt_q;
  logic [N-1:0]  num_q;
  logic [W:0]    dvs_q;
  logic [W:0]    rem_q, rem_nxt;
  logic [N-2:0]  quo_q;
  logic          q_bit;
  logic [N-1:0]  q_final;
  logic          neg_q, dneg_q, dz_q;
  logic [W-1:0]  abs_data, abs_div;
  logic [W-1:0]  res_val;
  logic          res_sat;

  // A W-bit unsigned magnitude is exact even for -2^(W-1).
  assign abs_data = data_i[W-1] ? ('0 - data_i) : data_i;
  assign abs_div  = div_i[W-1]  ? ('0 - div_i)  : div_i;

  assign busy    = (state_q == CALC);
  assign q_final = {quo_q, q_bit};

  divide_fix_step #(.W(W)) u_step (
    .rem_i     (rem_q),
    .num_bit_i (num_q[N-1]),
    .dvs_i     (dvs_q),
    .rem_o     (rem_nxt),
    .q_bit_o   (q_bit)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (data_i_en) begin
          load    = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (cnt_q == '0) begin
          last    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Result forming: divide-by-zero override, then sign-dependent clamp.
  always_comb begin
    res_val = q_final[W-1:0];
    res_sat = 1'b0;
    if (dz_q) begin
      res_sat = 1'b1;
      res_val = dneg_q ? MIN_NEG : MAX_POS;
    end else if (neg_q) begin
      if (q_final > MIN_NEG_N) begin
        res_sat = 1'b1;
        res_val = MIN_NEG;
      end else begin
        res_val = '0 - q_final[W-1:0];
      end
    end else if (q_final > MAX_POS_N) begin
      res_sat = 1'b1;
      res_val = MAX_POS;
    end
  end

  // Operand latch, iteration registers and registered result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      num_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      neg_q      <= 1'b0;
      dneg_q     <= 1'b0;
      dz_q       <= 1'b0;
      data_o_en  <= 1'b0;
      data_o     <= '0;
      sat_o      <= 1'b0;
      div_zero_o <= 1'b0;
    end else begin
      data_o_en <= last;
      if (load) begin
        neg_q  <= data_i[W-1] ^ div_i[W-1];
        dneg_q <= data_i[W-1];
        dz_q   <= (div_i == '0);
        num_q  <= {abs_data, {width_W{1'b0}}};
        dvs_q  <= {1'b0, abs_div};
        rem_q  <= '0;
        quo_q  <= '0;
        cnt_q  <= CNT_LAST;
      end else if (step) begin
        num_q <= {num_q[N-2:0], 1'b0};
        rem_q <= rem_nxt;
        quo_q <= q_final[N-2:0];
        if (!last) cnt_q <= cnt_q - 1'b1;
      end
      if (last) begin
        data_o     <= res_val;
        sat_o      <= res_sat;
        div_zero_o <= dz_q;
      end
    end
  end

endmodule

// File: tb/tb_divide_fix_seq.sv
// Directed self-checking bench for divide_fix_seq at default parameters.
module tb_divide_fix_seq;

  localparam int W   = 25;
  localparam int LAT = 45;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          data_i_en = 1'b0;
  logic [W-1:0]  data_i = '0;
  logic [W-1:0]  div_i = '0;
  logic          busy, data_o_en, sat_o, div_zero_o;
  logic [W-1:0]  data_o;

  int n_checks = 0;
  int n_fail   = 0;

  divide_fix_seq #(.width_H(5), .width_W(20)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_i_en  (data_i_en),
    .data_i     (data_i),
    .div_i      (div_i),
    .busy       (busy),
    .data_o_en  (data_o_en),
    .data_o     (data_o),
    .sat_o      (sat_o),
    .div_zero_o (div_zero_o)
  );

  always #5 clk = ~clk;

  // Stimulus only: strobe one operand pair, then wait (bounded) for the result.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic s, output logic dz,
                       output int lat, output logic busy_acc, output logic busy_res);
    logic got;
    @(negedge clk);
    data_i = a; div_i = b; data_i_en = 1'b1;
    @(posedge clk); #1;
    data_i_en = 1'b0;
    data_i = 25'h0A5A5A5; div_i = 25'h1234567;
    busy_acc = busy;
    got = 1'b0; lat = 0; q = '0; s = 1'b0; dz = 1'b0; busy_res = 1'b1;
    while (!got && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (data_o_en) begin
        got = 1'b1; q = data_o; s = sat_o; dz = div_zero_o; busy_res = busy;
      end
    end
    if (!got) lat = -1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2;
    n_checks++;
    if ({busy, data_o_en, sat_o, div_zero_o} !== 4'b0000 || data_o !== '0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b en=%b sat=%b dz=%b data_o=%h required all 0",
               busy, data_o_en, sat_o, div_zero_o, data_o);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic();
    logic [W-1:0] q; logic s, dz, ba, br; int lat;
    do_op(25'h0300000, 25'h0200000, q, s, dz, lat, ba, br);
    n_checks++;
    if (lat !== LAT) begin n_fail++; $display("FAIL basic_latency: got %0d required %0d", lat, LAT); end
    n_checks++;
    if (q !== 25'h0180000 || s !== 1'b0 || dz !== 1'b0) begin
      n_fail++; $display("FAIL basic_3div2: data_o=%h sat=%b dz=%b required 0180000 0 0", q, s, dz);
    end
    n_checks++;
    if (ba !== 1'b1 || br !== 1'b0) begin
      n_fail++; $display("FAIL basic_busy: after accept=%b at result=%b required 1 0", ba, br);
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (data_o !== 25'h0180000 || data_o_en !== 1'b0) begin
      n_fail++; $display("FAIL basic_hold: data_o=%h en=%b required 0180000 0", data_o, data_o_en);
    end
  endtask

  task automatic test_neg_third();
    logic [W-1:0] q; logic s, dz, ba, br; int lat;
    do_op(25'h1F00000, 25'h0300000, q, s, dz, lat, ba, br);
    n_checks++;
    if (q !== 25'h1FAAAAB || s !== 1'b0 || dz !== 1'b0 || lat !== LAT) begin
      n_fail++; $display("FAIL neg_third: data_o=%h sat=%b dz=%b lat=%0d required 1faaaab 0 0 45", q, s, dz, lat);
    end
  endtask

  task automatic test_overflow();
    logic [W-1:0] q; logic s, dz, ba, br; int lat;
    do_op(25'h0F00000, 25'h0000400, q, s, dz, lat, ba, br);
    n_checks++;
    if (q !== 25'h0FFFFFF || s !== 1'b1 || dz !== 1'b0) begin
      n_fail++; $display("FAIL overflow_pos: data_o=%h sat=%b dz=%b required 0ffffff 1 0", q, s, dz);
    end
    do_op(25'h1000000, 25'h1F00000, q, s, dz, lat, ba, br);
    n_checks++;
    if (q !== 25'h0FFFFFF || s !== 1'b1 || dz !== 1'b0) begin
      n_fail++; $display("FAIL overflow_minneg_by_m1: data_o=%h sat=%b dz=%b required 0ffffff 1 0", q, s, dz);
    end
  endtask

  task automatic test_div_zero();
    logic [W-1:0] q; logic s, dz, ba, br; int lat;
    do_op(25'h1E00000, 25'h0000000, q, s, dz, lat, ba, br);
    n_checks++;
    if (q !== 25'h1000000 || s !== 1'b1 || dz !== 1'b1 || lat !== LAT) begin
      n_fail++; $display("FAIL divzero_neg: data_o=%h sat=%b dz=%b lat=%0d required 1000000 1 1 45", q, s, dz, lat);
    end
    do_op(25'h0100000, 25'h0000000, q, s, dz, lat, ba, br);
    n_checks++;
    if (q !== 25'h0FFFFFF || s !== 1'b1 || dz !== 1'b1) begin
      n_fail++; $display("FAIL divzero_pos: data_o=%h sat=%b dz=%b required 0ffffff 1 1", q, s, dz);
    end
  endtask

  task automatic test_boundaries();
    logic [W-1:0] q; logic s, dz, ba, br; int lat;
    do_op(25'h1000000, 25'h0100000, q, s, dz, lat, ba, br);
    n_checks++;
    if (q !== 25'h1000000 || s !== 1'b0 || dz !== 1'b0) begin
      n_fail++; $display("FAIL exact_minneg: data_o=%h sat=%b dz=%b required 1000000 0 0", q, s, dz);
    end
    do_op(25'h0000000, 25'h1B00000, q, s, dz, lat, ba, br);
    n_checks++;
    if (q !== 25'h0000000 || s !== 1'b0 || dz !== 1'b0) begin
      n_fail++; $display("FAIL zero_dividend: data_o=%h sat=%b dz=%b required 0000000 0 0", q, s, dz);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] res [0:3];
    int rt [0:3];
    int nres, c_acc;
    logic c_sent;
    nres = 0; c_acc = -1; c_sent = 1'b0;
    @(negedge clk);
    data_i = 25'h0100000; div_i = 25'h0100000; data_i_en = 1'b1;
    @(posedge clk);
    for (int unsigned t = 1; t <= 120; t++) begin
      @(negedge clk);
      data_i_en = 1'b0;
      if (t == 10) begin
        data_i = 25'h0500000; div_i = 25'h0100000; data_i_en = 1'b1;
      end
      if (data_o_en && nres == 1 && !c_sent) begin
        data_i = 25'h0100000; div_i = 25'h0200000; data_i_en = 1'b1;
        c_sent = 1'b1; c_acc = int'(t);
      end
      @(posedge clk); #1;
      if (data_o_en && nres < 4) begin
        res[nres] = data_o; rt[nres] = int'(t); nres++;
      end
    end
    data_i_en = 1'b0;
    n_checks++;
    if (nres !== 2) begin
      n_fail++; $display("FAIL b2b_count: got %0d results required 2", nres);
    end else begin
      n_checks++;
      if (res[0] !== 25'h0100000 || rt[0] !== LAT) begin
        n_fail++; $display("FAIL b2b_first: data_o=%h at %0d required 0100000 at 45", res[0], rt[0]);
      end
      n_checks++;
      if (res[1] !== 25'h0080000 || rt[1] !== c_acc + LAT) begin
        n_fail++; $display("FAIL b2b_second: data_o=%h at %0d required 0080000 at %0d", res[1], rt[1], c_acc + LAT);
      end
    end
  endtask

  task automatic test_reset_midop();
    logic [W-1:0] q; logic s, dz, ba, br; int lat, strobes;
    @(negedge clk);
    data_i = 25'h0100000; div_i = 25'h0100000; data_i_en = 1'b1;
    @(posedge clk); #1;
    data_i_en = 1'b0;
    repeat (19) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({busy, data_o_en, sat_o, div_zero_o} !== 4'b0000 || data_o !== '0) begin
      n_fail++;
      $display("FAIL midop_async_clear: busy=%b en=%b sat=%b dz=%b data_o=%h required all 0",
               busy, data_o_en, sat_o, div_zero_o, data_o);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    strobes = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (data_o_en) strobes++;
    end
    n_checks++;
    if (strobes !== 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL midop_no_strobe: strobes=%0d busy=%b required 0 0", strobes, busy);
    end
    do_op(25'h0300000, 25'h0200000, q, s, dz, lat, ba, br);
    n_checks++;
    if (q !== 25'h0180000 || lat !== LAT || s !== 1'b0 || dz !== 1'b0) begin
      n_fail++; $display("FAIL midop_restart: data_o=%h lat=%0d sat=%b dz=%b required 0180000 45 0 0", q, lat, s, dz);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_neg_third();
    test_overflow();
    test_div_zero();
    test_boundaries();
    test_back_to_back();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
